// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a single LIFO stack: grants ops, sequences pop latency,
// owns the occupancy count. Define STACK_ARB_FIXED_PRIO_EN for fixed priority (requester 0).
module stack_arbiter #(
    parameter int DATA_WIDTH  = 4,
    parameter int STACK_DEPTH = 64,
    parameter int CNT_W       = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req,
    input  logic [1:0]              op,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    input  logic                    flush,
    output logic [1:0]              ack,
    output logic                    err,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rid,
    output logic                    flush_done,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    stk_push,
    output logic                    stk_pop,
    output logic                    stk_reset,
    output logic [DATA_WIDTH-1:0]   stk_d,
    input  logic [DATA_WIDTH-1:0]   stk_q
);

    typedef enum logic [2:0] {StIdle, StPush, StPop, StPopW, StFlush} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    rr_last_q, rr_last_d;
    logic                    w_q, w_d;
    logic                    err_pend_q, err_pend_d;
    logic [1:0]              ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rid_q, rid_d;
    logic                    flush_done_q, flush_done_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    stk_push_q, stk_push_d;
    logic                    stk_pop_q, stk_pop_d;
    logic                    stk_reset_q, stk_reset_d;
    logic [DATA_WIDTH-1:0]   stk_d_q, stk_d_d;
    logic                    win;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [1:0]              w_onehot;

`ifdef STACK_ARB_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    assign win = (&req) ? ~rr_last_q : req[1];
`endif
    assign win_data = win ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
    assign w_onehot = w_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rr_last_d    = rr_last_q;
        w_d          = w_q;
        err_pend_d   = 1'b0;
        ack_d        = 2'b00;
        err_d        = 1'b0;
        rvalid_d     = 1'b0;
        rdata_d      = '0;
        rid_d        = 1'b0;
        flush_done_d = 1'b0;
        stk_push_d   = 1'b0;
        stk_pop_d    = 1'b0;
        stk_reset_d  = 1'b0;
        stk_d_d      = '0;
        unique case (state_q)
            StIdle: begin
                // A rejected op acks one cycle later so err latency matches push latency
                if (err_pend_q) begin
                    ack_d = w_onehot;
                    err_d = 1'b1;
                    rid_d = w_q;
                end else if (flush) begin
                    state_d     = StFlush;
                    stk_reset_d = 1'b1;
                end else if (|req) begin
                    w_d       = win;
                    rr_last_d = win;
                    if (op[win] ? full_q : empty_q) begin
                        err_pend_d = 1'b1;
                    end else if (op[win]) begin
                        state_d    = StPush;
                        stk_push_d = 1'b1;
                        stk_d_d    = win_data;
                    end else begin
                        state_d   = StPop;
                        stk_pop_d = 1'b1;
                    end
                end
            end
            StPush: begin
                count_d = count_q + CNT_W'(1);
                ack_d   = w_onehot;
                rid_d   = w_q;
                state_d = StIdle;
            end
            StPop: begin
                count_d = count_q - CNT_W'(1);
                state_d = StPopW;
            end
            StPopW: begin
                rdata_d  = stk_q;
                rvalid_d = 1'b1;
                ack_d    = w_onehot;
                rid_d    = w_q;
                state_d  = StIdle;
            end
            StFlush: begin
                count_d      = '0;
                flush_done_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
        full_d  = (count_d == CNT_W'(STACK_DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            rr_last_q    <= 1'b1;
            w_q          <= 1'b0;
            err_pend_q   <= 1'b0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rid_q        <= 1'b0;
            flush_done_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            stk_push_q   <= 1'b0;
            stk_pop_q    <= 1'b0;
            stk_reset_q  <= 1'b0;
            stk_d_q      <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rr_last_q    <= rr_last_d;
            w_q          <= w_d;
            err_pend_q   <= err_pend_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rid_q        <= rid_d;
            flush_done_q <= flush_done_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            stk_push_q   <= stk_push_d;
            stk_pop_q    <= stk_pop_d;
            stk_reset_q  <= stk_reset_d;
            stk_d_q      <= stk_d_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign rid        = rid_q;
    assign flush_done = flush_done_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign stk_push   = stk_push_q;
    assign stk_pop    = stk_pop_q;
    assign stk_reset  = stk_reset_q;
    assign stk_d      = stk_d_q;

endmodule
